ccu_mst_hazard_guard: RTL and testbench



---
 rtl/ccu_mst_hazard_guard_pkg.sv | 69 ++++++
 rtl/ccu_wr_table.sv | 101 ++++++++++
 rtl/ccu_mst_hazard_guard.sv | 105 ++++++++++
 tb/tb_ccu_mst_hazard_guard.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_mst_hazard_guard_pkg.sv
// Shared AXI channel/bundle types for the CCU master-side hazard guard and
// the line-offset helper used to derive the compared address bits.
package ccu_mst_hazard_guard_pkg;

  localparam int unsigned AxiAddrW = 64;
  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiDataW = 64;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [5:0]          atop;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  function automatic int unsigned ccu_line_off_w(input int unsigned line_width);
    return unsigned'($clog2(line_width / 8));
  endfunction

endpackage

// File: rtl/ccu_wr_table.sv
// Outstanding-write table: allocates the lowest free entry, frees the oldest
// entry of a given ID, and reports per-entry line matches.
module ccu_wr_table #(
  parameter int unsigned MaxWrTrans = 8,
  parameter int unsigned LineW      = 60,
  parameter int unsigned IdW        = 4,
  localparam int unsigned RankW     = $clog2(MaxWrTrans),
  localparam int unsigned CntW      = $clog2(MaxWrTrans + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_i,
  input  logic [LineW-1:0]      alloc_line_i,
  input  logic [IdW-1:0]        alloc_id_i,
  input  logic                  free_i,
  input  logic [IdW-1:0]        free_id_i,
  input  logic [LineW-1:0]      match_line_i,
  output logic                  full_o,
  output logic [CntW-1:0]       count_o,
  output logic                  free_hit_o,
  output logic [MaxWrTrans-1:0] match_o
);

  typedef struct packed {
    logic             valid;
    logic [LineW-1:0] line;
    logic [IdW-1:0]   id;
    logic [RankW-1:0] rank;
  } entry_t;

  entry_t [MaxWrTrans-1:0] tbl_q, tbl_d;
  logic   [CntW-1:0]       count_q, count_d;

  logic             free_hit, free_en, alloc_found, alloc_en;
  logic [RankW-1:0] free_rank;
  int unsigned      free_idx, alloc_idx;

  always_comb begin
    free_hit    = 1'b0;
    free_idx    = 0;
    free_rank   = '1;
    alloc_found = 1'b0;
    alloc_idx   = 0;
    // Ranks of valid entries are unique, so the smallest rank is the oldest.
    for (int unsigned i = 0; i < MaxWrTrans; i++) begin
      if (tbl_q[i].valid && tbl_q[i].id == free_id_i &&
          (!free_hit || tbl_q[i].rank < free_rank)) begin
        free_hit  = 1'b1;
        free_idx  = i;
        free_rank = tbl_q[i].rank;
      end
      if (!tbl_q[i].valid && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = i;
      end
    end
    free_en  = free_i & free_hit;
    alloc_en = alloc_i & alloc_found;

    tbl_d = tbl_q;
    for (int unsigned i = 0; i < MaxWrTrans; i++) begin
      if (free_en) begin
        if (i == free_idx) begin
          tbl_d[i].valid = 1'b0;
        end else if (tbl_q[i].valid && tbl_q[i].rank > free_rank) begin
          tbl_d[i].rank = tbl_q[i].rank - 1'b1;
        end
      end
    end
    // A freed entry always ranks below count, so a concurrent alloc takes count-1.
    if (alloc_en) begin
      tbl_d[alloc_idx].valid = 1'b1;
      tbl_d[alloc_idx].line  = alloc_line_i;
      tbl_d[alloc_idx].id    = alloc_id_i;
      tbl_d[alloc_idx].rank  = RankW'(count_q - CntW'(free_en));
    end
    count_d = count_q + CntW'(alloc_en) - CntW'(free_en);
  end

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < MaxWrTrans; i++) begin
      match_o[i] = tbl_q[i].valid && (tbl_q[i].line == match_line_i);
    end
  end

  assign full_o     = (count_q == CntW'(MaxWrTrans));
  assign count_o    = count_q;
  assign free_hit_o = free_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q   <= '0;
      count_q <= '0;
    end else begin
      tbl_q   <= tbl_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ccu_mst_hazard_guard.sv
// Holds reads to cache lines with writes still outstanding downstream of the
// CCU mux. Optional stall statistics via CCU_HAZARD_STATS_EN.
module ccu_mst_hazard_guard
  import ccu_mst_hazard_guard_pkg::*;
#(
  parameter int unsigned MaxWrTrans      = 8,
  parameter int unsigned AxiAddrWidth    = 64,
  parameter int unsigned AxiIdWidth      = 4,
  parameter int unsigned DcacheLineWidth = 128,
  parameter type         req_t           = axi_req_t,
  parameter type         resp_t          = axi_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  req_t        slv_req_i,
  output resp_t       slv_resp_o,
  output req_t        mst_req_o,
  input  resp_t       mst_resp_i,
  output logic        busy_o,
  output logic [31:0] stall_cycles_o
);

  localparam int unsigned OffW  = ccu_line_off_w(DcacheLineWidth);
  localparam int unsigned LineW = AxiAddrWidth - OffW;
  localparam int unsigned CntW  = $clog2(MaxWrTrans + 1);

  logic [LineW-1:0]      aw_line, ar_line;
  logic [MaxWrTrans-1:0] match;
  logic [CntW-1:0]       count;
  logic                  full, free_hit;
  logic                  aw_hs, b_hs, ar_hit, ar_hold, ar_out;
  logic                  ar_committed_q, ar_committed_d;

  assign aw_line = slv_req_i.aw.addr[AxiAddrWidth-1:OffW];
  assign ar_line = slv_req_i.ar.addr[AxiAddrWidth-1:OffW];

  ccu_wr_table #(
    .MaxWrTrans (MaxWrTrans),
    .LineW      (LineW),
    .IdW        (AxiIdWidth)
  ) i_wr_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_i      (aw_hs),
    .alloc_line_i (aw_line),
    .alloc_id_i   (slv_req_i.aw.id),
    .free_i       (b_hs),
    .free_id_i    (mst_resp_i.b.id),
    .match_line_i (ar_line),
    .full_o       (full),
    .count_o      (count),
    .free_hit_o   (free_hit),
    .match_o      (match)
  );

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;

    aw_hs   = slv_req_i.aw_valid & ~full & mst_resp_i.aw_ready;
    b_hs    = mst_resp_i.b_valid & slv_req_i.b_ready;
    ar_hit  = slv_req_i.ar_valid & ((|match) | (aw_hs & (aw_line == ar_line)));
    ar_hold = ~ar_committed_q & ar_hit;
    ar_out  = slv_req_i.ar_valid & ~ar_hold;

    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~full;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~full;
    mst_req_o.ar_valid  = ar_out;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_hold;

    // Once presented, an AR stays committed until it handshakes.
    ar_committed_d = ar_committed_q;
    if (ar_out) ar_committed_d = ~mst_resp_i.ar_ready;
  end

  assign busy_o = (count != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ar_committed_q <= 1'b0;
    else         ar_committed_q <= ar_committed_d;
  end

`ifdef CCU_HAZARD_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ar_hold && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
  b_has_entry: assert property (@(posedge clk_i) disable iff (!rst_ni) b_hs |-> free_hit);
`endif

endmodule

// File: tb/tb_ccu_mst_hazard_guard.sv
// Bench for ccu_mst_hazard_guard: directed scenarios plus randomized traffic
// against an ordered-queue model of outstanding writes.
module tb_ccu_mst_hazard_guard;
  import ccu_mst_hazard_guard_pkg::*;

`ifdef CCU_HAZARD_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  axi_req_t    slv_req, mst_req;
  axi_resp_t   slv_resp, mst_resp;
  logic        busy;
  logic [31:0] stall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] line;
  } wr_t;
  wr_t         q[$];
  bit          presented;
  int unsigned stall_exp;

  always #5 clk = ~clk;

  ccu_mst_hazard_guard #(
    .MaxWrTrans      (8),
    .AxiAddrWidth    (64),
    .AxiIdWidth      (4),
    .DcacheLineWidth (128),
    .req_t           (axi_req_t),
    .resp_t          (axi_resp_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_req_i      (slv_req),
    .slv_resp_o     (slv_resp),
    .mst_req_o      (mst_req),
    .mst_resp_i     (mst_resp),
    .busy_o         (busy),
    .stall_cycles_o (stall)
  );

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a >> 4;
  endfunction

  function automatic bit m_full();
    return q.size() >= 8;
  endfunction

  // Read must wait: AR offered, not already presented, and a write to its line is outstanding or accepted now.
  function automatic bit m_hold();
    bit aw_acc;
    if (!slv_req.ar_valid || presented) return 1'b0;
    aw_acc = slv_req.aw_valid && !m_full() && mst_resp.aw_ready;
    if (aw_acc && line_of(slv_req.aw.addr) == line_of(slv_req.ar.addr)) return 1'b1;
    foreach (q[i]) if (q[i].line == line_of(slv_req.ar.addr)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_stall();
    return StatsEn ? stall_exp : 32'd0;
  endfunction

  task automatic tick();
    bit          aw_acc, b_acc, hold, ar_fwd, ar_rdy;
    wr_t         nw;
    logic [3:0]  bid;
    aw_acc  = slv_req.aw_valid && !m_full() && mst_resp.aw_ready;
    b_acc   = mst_resp.b_valid && slv_req.b_ready;
    hold    = m_hold();
    ar_fwd  = slv_req.ar_valid && !hold;
    ar_rdy  = mst_resp.ar_ready;
    nw.id   = slv_req.aw.id;
    nw.line = line_of(slv_req.aw.addr);
    bid     = mst_resp.b.id;
    @(posedge clk);
    if (b_acc) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].id == bid) begin
          q.delete(i);
          break;
        end
      end
    end
    if (aw_acc) q.push_back(nw);
    if (ar_fwd) presented = !ar_rdy;
    if (hold && stall_exp != 32'hFFFF_FFFF) stall_exp++;
    #1;
  endtask

  task automatic idle();
    slv_req           = '0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    mst_resp          = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    q.delete();
    presented = 1'b0;
    stall_exp = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    slv_req.ar_valid   = 1'b1;
    slv_req.ar.addr    = 64'h1000;
    slv_req.aw_valid   = 1'b1;
    slv_req.aw.addr    = 64'h9000;
    mst_resp.aw_ready  = 1'b0;
    mst_resp.ar_ready  = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (stall !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall); end
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL reset_ar_pass got=%0b exp=1", mst_req.ar_valid); end
    checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL reset_aw_pass got=%0b exp=1", mst_req.aw_valid); end
    do_reset();
  endtask

  task automatic test_ar_hazard();
    do_reset();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1; slv_req.aw.addr = 64'h1000;
    #1;
    checks++; if (slv_resp.aw_ready !== 1'b1) begin errors++; $display("FAIL haz_aw_ready got=%0b exp=1", slv_resp.aw_ready); end
    tick();
    idle();
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h1010; mst_resp.ar_ready = 1'b1;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL haz_other_line got=%0b exp=1", mst_req.ar_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL haz_busy got=%0b exp=1", busy); end
    tick();
    slv_req.ar.addr = 64'h1008;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL haz_held_valid got=%0b exp=0", mst_req.ar_valid); end
    checks++; if (slv_resp.ar_ready !== 1'b0) begin errors++; $display("FAIL haz_held_ready got=%0b exp=0", slv_resp.ar_ready); end
    tick(); tick();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL haz_b_cycle got=%0b exp=0", mst_req.ar_valid); end
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL haz_release got=%0b exp=1", mst_req.ar_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL haz_busy_clear got=%0b exp=0", busy); end
    tick();
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd5;
      slv_req.aw.addr = 64'h6000 + 64'(i) * 64'h40;
      tick();
    end
    slv_req.aw.addr = 64'h7000;
    #1;
    checks++; if (slv_resp.aw_ready !== 1'b0) begin errors++; $display("FAIL full_aw_ready got=%0b exp=0", slv_resp.aw_ready); end
    checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL full_aw_valid got=%0b exp=0", mst_req.aw_valid); end
    tick();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd5;
    #1;
    checks++; if (slv_resp.aw_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%0b exp=0", slv_resp.aw_ready); end
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    checks++; if (slv_resp.aw_ready !== 1'b1) begin errors++; $display("FAIL full_after_free got=%0b exp=1", slv_resp.aw_ready); end
    checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL full_after_free_v got=%0b exp=1", mst_req.aw_valid); end
    tick();
    idle();
  endtask

  task automatic test_same_id_order();
    do_reset();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd2; slv_req.aw.addr = 64'h2000;
    tick();
    slv_req.aw.addr = 64'h3000;
    tick();
    idle();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd2;
    tick();
    idle();
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h3000; mst_resp.ar_ready = 1'b0;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL order_young_held got=%0b exp=0", mst_req.ar_valid); end
    slv_req.ar.addr = 64'h2000; mst_resp.ar_ready = 1'b1;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL order_old_freed got=%0b exp=1", mst_req.ar_valid); end
    tick();
    idle();
  endtask

  task automatic test_committed_ar();
    do_reset();
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h4000; slv_req.ar.id = 4'd7;
    mst_resp.ar_ready = 1'b0;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL commit_present got=%0b exp=1", mst_req.ar_valid); end
    tick();
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'h4000; slv_req.aw.id = 4'd6;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL commit_aw_same got=%0b exp=1", mst_req.ar_valid); end
    checks++; if (mst_req.ar.addr !== 64'h4000) begin errors++; $display("FAIL commit_addr got=%0h exp=4000", mst_req.ar.addr); end
    tick();
    slv_req.aw_valid = 1'b0;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL commit_kept got=%0b exp=1", mst_req.ar_valid); end
    mst_resp.ar_ready = 1'b1;
    #1;
    checks++; if (slv_resp.ar_ready !== 1'b1) begin errors++; $display("FAIL commit_ready got=%0b exp=1", slv_resp.ar_ready); end
    tick();
    #1;
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL commit_new_held got=%0b exp=0", mst_req.ar_valid); end
    tick();
    idle();
  endtask

  task automatic test_stats();
    do_reset();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd3; slv_req.aw.addr = 64'h5000;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h5004; mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall !== (StatsEn ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stats_five got=%0d exp=%0d", stall, StatsEn ? 5 : 0); end
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3;
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL stats_release got=%0b exp=1", mst_req.ar_valid); end
    tick();
    checks++; if (stall !== (StatsEn ? 32'd6 : 32'd0)) begin errors++; $display("FAIL stats_six got=%0d exp=%0d", stall, StatsEn ? 6 : 0); end
    idle();
  endtask

  task automatic test_random();
    bit hold;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      slv_req.aw_valid  = 1'($urandom_range(0, 1));
      slv_req.aw.id     = 4'($urandom_range(0, 3));
      slv_req.aw.addr   = 64'h8000 + 64'($urandom_range(0, 5)) * 64'h10 + 64'($urandom_range(0, 15));
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = q[$urandom_range(0, q.size() - 1)].id;
      end else begin
        mst_resp.b_valid = 1'b0;
      end
      if (!presented) begin
        slv_req.ar_valid = 1'($urandom_range(0, 1));
        slv_req.ar.addr  = 64'h8000 + 64'($urandom_range(0, 5)) * 64'h10 + 64'($urandom_range(0, 15));
      end
      mst_resp.ar_ready = 1'($urandom_range(0, 1));
      #1;
      hold = m_hold();
      checks++; if (mst_req.ar_valid !== (slv_req.ar_valid && !hold)) begin errors++; $display("FAIL rnd_ar_valid n=%0d got=%0b exp=%0b", n, mst_req.ar_valid, slv_req.ar_valid && !hold); end
      checks++; if (slv_resp.ar_ready !== (mst_resp.ar_ready && !hold)) begin errors++; $display("FAIL rnd_ar_ready n=%0d got=%0b exp=%0b", n, slv_resp.ar_ready, mst_resp.ar_ready && !hold); end
      checks++; if (mst_req.aw_valid !== (slv_req.aw_valid && !m_full())) begin errors++; $display("FAIL rnd_aw_valid n=%0d got=%0b exp=%0b", n, mst_req.aw_valid, slv_req.aw_valid && !m_full()); end
      checks++; if (slv_resp.aw_ready !== (mst_resp.aw_ready && !m_full())) begin errors++; $display("FAIL rnd_aw_ready n=%0d got=%0b exp=%0b", n, slv_resp.aw_ready, mst_resp.aw_ready && !m_full()); end
      checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, busy, q.size() != 0); end
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall, m_stall()); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ar_hazard();
    test_full();
    test_same_id_order();
    test_committed_ar();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
